// File: rtl/ct_clint_pkg.sv
// Shared constants, FSM state and address-decode helper for the n-core CLINT.
package ct_clint_pkg;

  localparam logic [15:0] MSIP_BASE  = 16'h0000;
  localparam logic [15:0] MTCMP_BASE = 16'h4000;
  localparam logic [15:0] SSIP_BASE  = 16'hC000;
  localparam logic [15:0] STCMP_BASE = 16'hD000;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_S = 2'b01;

  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {IDLE, SETUP, ACC} state_t;

  typedef enum logic [2:0] {SEL_NONE, SEL_MSIP, SEL_MTCMP, SEL_SSIP, SEL_STCMP} sel_t;

  typedef struct packed {
    sel_t       sel;
    logic [2:0] idx;
    logic       hi;
    logic       err;
  } dec_t;

  // Each bank spans 8 slots (MSIP/SSIP 4 bytes each, compares 8 bytes each).
  function automatic dec_t decode(input logic [15:0] off, input logic [1:0] prot,
                                  input int unsigned core_num);
    dec_t d;
    logic m_only;
    logic priv_ok;
    d.sel = SEL_NONE;
    d.idx = 3'd0;
    d.hi  = 1'b0;
    if (off[15:5] == MSIP_BASE[15:5]) begin
      d.sel = SEL_MSIP;
      d.idx = off[4:2];
    end else if (off[15:6] == MTCMP_BASE[15:6]) begin
      d.sel = SEL_MTCMP;
      d.idx = off[5:3];
      d.hi  = off[2];
    end else if (off[15:5] == SSIP_BASE[15:5]) begin
      d.sel = SEL_SSIP;
      d.idx = off[4:2];
    end else if (off[15:6] == STCMP_BASE[15:6]) begin
      d.sel = SEL_STCMP;
      d.idx = off[5:3];
      d.hi  = off[2];
    end
    m_only  = (d.sel == SEL_MSIP) || (d.sel == SEL_MTCMP);
    priv_ok = (prot == PRIV_M) || ((prot == PRIV_S) && !m_only);
    d.err   = (d.sel == SEL_NONE) || (off[1:0] != 2'b00) ||
              ({29'd0, d.idx} >= core_num) || !priv_ok;
    return d;
  endfunction

endpackage

// File: rtl/ct_clint_ncore_if.sv
// APB slave bus of the CLINT, including the APB clock-enable.
interface ct_clint_ncore_if;
  logic        apb_clk_en;
  logic        psel_clint;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [1:0]  pprot;
  logic [31:0] prdata_clint;
  logic        pready_clint;
  logic        perr_clint;

  modport master (
    output apb_clk_en, psel_clint, penable, pwrite, paddr, pwdata, pprot,
    input  prdata_clint, pready_clint, perr_clint
  );

  modport slave (
    input  apb_clk_en, psel_clint, penable, pwrite, paddr, pwdata, pprot,
    output prdata_clint, pready_clint, perr_clint
  );
endinterface

// File: rtl/ct_clint_ncore_core_slice.sv
// Per-core software-interrupt bits, 64-bit timer compares and their comparators.
module ct_clint_core_slice
  import ct_clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic [63:0] mtime,
  input  logic        wr_msip,
  input  logic        wr_ssip,
  input  logic        wr_mtcmp_lo,
  input  logic        wr_mtcmp_hi,
  input  logic        wr_stcmp_lo,
  input  logic        wr_stcmp_hi,
  input  logic [31:0] wdata,
  output logic        msip,
  output logic        ssip,
  output logic [63:0] mtcmp,
  output logic [63:0] stcmp,
  output logic        mt_int,
  output logic        st_int
);
  logic        msip_reg, ssip_reg, mt_int_reg, st_int_reg;
  logic [63:0] mtcmp_reg, stcmp_reg;

  // Comparators see the pre-write compare value; a write takes effect next cycle.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      msip_reg   <= 1'b0;
      ssip_reg   <= 1'b0;
      mtcmp_reg  <= CMP_RST;
      stcmp_reg  <= CMP_RST;
      mt_int_reg <= 1'b0;
      st_int_reg <= 1'b0;
    end else begin
      if (wr_msip)     msip_reg         <= wdata[0];
      if (wr_ssip)     ssip_reg         <= wdata[0];
      if (wr_mtcmp_lo) mtcmp_reg[31:0]  <= wdata;
      if (wr_mtcmp_hi) mtcmp_reg[63:32] <= wdata;
      if (wr_stcmp_lo) stcmp_reg[31:0]  <= wdata;
      if (wr_stcmp_hi) stcmp_reg[63:32] <= wdata;
      mt_int_reg <= (mtime >= mtcmp_reg);
      st_int_reg <= (mtime >= stcmp_reg);
    end
  end

  assign msip   = msip_reg;
  assign ssip   = ssip_reg;
  assign mtcmp  = mtcmp_reg;
  assign stcmp  = stcmp_reg;
  assign mt_int = mt_int_reg;
  assign st_int = st_int_reg;
endmodule

// File: rtl/ct_clint_ncore.sv
// CLINT top: APB slave FSM, address decode/privilege check, read mux and per-core slices.
module ct_clint_ncore
  import ct_clint_pkg::*;
#(
  parameter int unsigned CORE_NUM = 4
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  ct_clint_ncore_if.slave     apb,
  input  logic [63:0]         sysio_clint_mtime,
  output logic [CORE_NUM-1:0] clint_ms_int,
  output logic [CORE_NUM-1:0] clint_ss_int,
  output logic [CORE_NUM-1:0] clint_mt_int,
  output logic [CORE_NUM-1:0] clint_st_int
);
  state_t      state_reg;
  dec_t        dec_next, dec_reg;
  logic        wr_reg, pready_reg, perr_reg, do_wr;
  logic [31:0] wdata_reg, prdata_reg, rd_data;
  logic        unused_addr_hi;

  logic [CORE_NUM-1:0] msip, ssip;
  logic [CORE_NUM-1:0] wr_msip, wr_ssip, wr_mtcmp_lo, wr_mtcmp_hi, wr_stcmp_lo, wr_stcmp_hi;
  logic [63:0]         mtcmp [CORE_NUM];
  logic [63:0]         stcmp [CORE_NUM];

  assign unused_addr_hi = ^apb.paddr[31:16];
  assign dec_next = decode(apb.paddr[15:0], apb.pprot, CORE_NUM);

  always_comb begin
    rd_data = 32'd0;
    for (int i = 0; i < int'(CORE_NUM); i++) begin
      if (dec_next.idx == 3'(i)) begin
        case (dec_next.sel)
          SEL_MSIP:  rd_data = {31'd0, msip[i]};
          SEL_SSIP:  rd_data = {31'd0, ssip[i]};
          SEL_MTCMP: rd_data = dec_next.hi ? mtcmp[i][63:32] : mtcmp[i][31:0];
          SEL_STCMP: rd_data = dec_next.hi ? stcmp[i][63:32] : stcmp[i][31:0];
          default:   rd_data = 32'd0;
        endcase
      end
    end
  end

  // Response is registered on the SETUP->ACC edge; the write lands on the ACC->IDLE edge.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_reg  <= IDLE;
      dec_reg    <= '0;
      wr_reg     <= 1'b0;
      wdata_reg  <= 32'd0;
      pready_reg <= 1'b0;
      perr_reg   <= 1'b0;
      prdata_reg <= 32'd0;
    end else if (apb.apb_clk_en) begin
      case (state_reg)
        IDLE: begin
          pready_reg <= 1'b0;
          perr_reg   <= 1'b0;
          prdata_reg <= 32'd0;
          if (apb.psel_clint && !apb.penable) state_reg <= SETUP;
        end
        SETUP: begin
          if (!apb.psel_clint) begin
            state_reg <= IDLE;
          end else if (apb.penable) begin
            state_reg  <= ACC;
            dec_reg    <= dec_next;
            wr_reg     <= apb.pwrite;
            wdata_reg  <= apb.pwdata;
            pready_reg <= 1'b1;
            perr_reg   <= dec_next.err;
            prdata_reg <= (dec_next.err || apb.pwrite) ? 32'd0 : rd_data;
          end
        end
        ACC: begin
          state_reg  <= IDLE;
          pready_reg <= 1'b0;
          perr_reg   <= 1'b0;
          prdata_reg <= 32'd0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign do_wr = apb.apb_clk_en && (state_reg == ACC) && wr_reg && !dec_reg.err;

  assign apb.pready_clint = pready_reg;
  assign apb.perr_clint   = perr_reg;
  assign apb.prdata_clint = prdata_reg;

  generate
    for (genvar gi = 0; gi < int'(CORE_NUM); gi++) begin : g_core
      logic hit;
      assign hit             = do_wr && (dec_reg.idx == 3'(gi));
      assign wr_msip[gi]     = hit && (dec_reg.sel == SEL_MSIP);
      assign wr_ssip[gi]     = hit && (dec_reg.sel == SEL_SSIP);
      assign wr_mtcmp_lo[gi] = hit && (dec_reg.sel == SEL_MTCMP) && !dec_reg.hi;
      assign wr_mtcmp_hi[gi] = hit && (dec_reg.sel == SEL_MTCMP) &&  dec_reg.hi;
      assign wr_stcmp_lo[gi] = hit && (dec_reg.sel == SEL_STCMP) && !dec_reg.hi;
      assign wr_stcmp_hi[gi] = hit && (dec_reg.sel == SEL_STCMP) &&  dec_reg.hi;

      ct_clint_core_slice u_slice (
        .clk         (forever_cpuclk),
        .rst_b       (cpurst_b),
        .mtime       (sysio_clint_mtime),
        .wr_msip     (wr_msip[gi]),
        .wr_ssip     (wr_ssip[gi]),
        .wr_mtcmp_lo (wr_mtcmp_lo[gi]),
        .wr_mtcmp_hi (wr_mtcmp_hi[gi]),
        .wr_stcmp_lo (wr_stcmp_lo[gi]),
        .wr_stcmp_hi (wr_stcmp_hi[gi]),
        .wdata       (wdata_reg),
        .msip        (msip[gi]),
        .ssip        (ssip[gi]),
        .mtcmp       (mtcmp[gi]),
        .stcmp       (stcmp[gi]),
        .mt_int      (clint_mt_int[gi]),
        .st_int      (clint_st_int[gi])
      );
    end
  endgenerate

  assign clint_ms_int = msip;
  assign clint_ss_int = ssip;
endmodule

// File: tb/tb_ct_clint_ncore.sv
// Scoreboard bench: a 4-core and a 3-core CLINT share one APB driver selected by tgt.
module tb_ct_clint_ncore;
  import ct_clint_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b = 1'b0;
  logic [63:0] mtime = 64'd0;
  logic        en = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = 32'd0, pwdata = 32'd0;
  logic [1:0]  pprot = 2'b11;
  int          tgt = 0;
  bit          en_mode = 1'b0;
  int          cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        perr;
    bit          chk_data;
  } exp_t;
  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;
  logic prev4 = 1'b0, prev3 = 1'b0;

  ct_clint_ncore_if apb4();
  ct_clint_ncore_if apb3();

  assign apb4.apb_clk_en = en;
  assign apb4.psel_clint = psel && (tgt == 0);
  assign apb4.penable    = penable;
  assign apb4.pwrite     = pwrite;
  assign apb4.paddr      = paddr;
  assign apb4.pwdata     = pwdata;
  assign apb4.pprot      = pprot;
  assign apb3.apb_clk_en = en;
  assign apb3.psel_clint = psel && (tgt == 1);
  assign apb3.penable    = penable;
  assign apb3.pwrite     = pwrite;
  assign apb3.paddr      = paddr;
  assign apb3.pwdata     = pwdata;
  assign apb3.pprot      = pprot;

  logic [3:0] ms4, ss4, mt4, st4;
  logic [2:0] ms3, ss3, mt3, st3;

  ct_clint_ncore #(.CORE_NUM(4)) dut4 (
    .forever_cpuclk(clk), .cpurst_b(rst_b), .apb(apb4), .sysio_clint_mtime(mtime),
    .clint_ms_int(ms4), .clint_ss_int(ss4), .clint_mt_int(mt4), .clint_st_int(st4));

  ct_clint_ncore #(.CORE_NUM(3)) dut3 (
    .forever_cpuclk(clk), .cpurst_b(rst_b), .apb(apb3), .sysio_clint_mtime(mtime),
    .clint_ms_int(ms3), .clint_ss_int(ss3), .clint_mt_int(mt3), .clint_st_int(st3));

  always @(posedge clk) begin
    #1;
    cyc++;
    en = en_mode ? (cyc % 4 == 0) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per rising pready.
  always @(negedge clk) begin
    if (apb4.pready_clint && !prev4) begin
      if (q4.size() == 0) chk("dut4_unexpected_resp", 64'd1, 64'd0);
      else begin
        e4 = q4.pop_front();
        chk({e4.name, "_perr"}, 64'(apb4.perr_clint), 64'(e4.perr));
        if (e4.chk_data) chk({e4.name, "_rdata"}, 64'(apb4.prdata_clint), 64'(e4.rdata));
      end
    end
    prev4 = apb4.pready_clint;
  end

  always @(negedge clk) begin
    if (apb3.pready_clint && !prev3) begin
      if (q3.size() == 0) chk("dut3_unexpected_resp", 64'd1, 64'd0);
      else begin
        e3 = q3.pop_front();
        chk({e3.name, "_perr"}, 64'(apb3.perr_clint), 64'(e3.perr));
        if (e3.chk_data) chk({e3.name, "_rdata"}, 64'(apb3.prdata_clint), 64'(e3.rdata));
      end
    end
    prev3 = apb3.pready_clint;
  end

  task automatic en_edge();
    do @(posedge clk); while (en !== 1'b1);
    #1;
  endtask

  task automatic xfer(input int t, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] prot, input logic [31:0] exp_rd, input logic exp_err,
                      input string name);
    exp_t e;
    bit   done;
    int   lat;
    logic rb;
    e.name = name; e.rdata = exp_rd; e.perr = exp_err; e.chk_data = !wr || exp_err;
    if (t == 0) q4.push_back(e); else q3.push_back(e);
    tgt = t; pwrite = wr; paddr = addr; pwdata = wd; pprot = prot;
    psel = 1'b1; penable = 1'b0;
    en_edge();
    penable = 1'b1;
    done = 1'b0; lat = 0;
    for (int k = 0; k < 16; k++) begin
      rb = (t == 0) ? apb4.pready_clint : apb3.pready_clint;
      en_edge();
      if (rb) begin done = 1'b1; lat = k; break; end
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    if (!done) chk({name, "_timeout"}, 64'd0, 64'd1);
    else       chk({name, "_lat"}, 64'(lat), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 64'(apb4.pready_clint), 64'd0);
    chk("rst_perr",   64'(apb4.perr_clint),   64'd0);
    chk("rst_prdata", 64'(apb4.prdata_clint), 64'd0);
    chk("rst_ints",   64'({ms4, ss4, mt4, st4}), 64'd0);
    rst_b = 1'b1;
    en_edge();

    // 1: compare reset values
    xfer(0, 1'b0, 32'h4000, 32'd0, PRIV_M, 32'hFFFF_FFFF, 1'b0, "mtcmp0_lo");
    xfer(0, 1'b0, 32'h4004, 32'd0, PRIV_M, 32'hFFFF_FFFF, 1'b0, "mtcmp0_hi");
    chk("ints_idle", 64'({ms4, ss4, mt4, st4}), 64'd0);

    // 2: MSIP core2
    xfer(0, 1'b1, 32'h0008, 32'hFFFF_FFFF, PRIV_M, 32'd0, 1'b0, "msip2_set");
    chk("ms_int_set", 64'(ms4), 64'h4);
    xfer(0, 1'b0, 32'h0008, 32'd0, PRIV_M, 32'd1, 1'b0, "msip2_rd");
    xfer(0, 1'b1, 32'h0008, 32'd0, PRIV_M, 32'd0, 1'b0, "msip2_clr");
    chk("ms_int_clr", 64'(ms4), 64'h0);

    // 3: STCMP1 = 0x1_0000_0000, carry boundary
    xfer(0, 1'b1, 32'hD008, 32'd0, PRIV_M, 32'd0, 1'b0, "stcmp1_lo");
    xfer(0, 1'b1, 32'hD00C, 32'd1, PRIV_M, 32'd0, 1'b0, "stcmp1_hi");
    mtime = 64'h0_FFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("st_below", 64'(st4), 64'h0);
    mtime = 64'h1_0000_0000;
    chk("st_no_early", 64'(st4), 64'h0);
    @(posedge clk); #1;
    chk("st_rise", 64'(st4), 64'h2);
    repeat (3) @(posedge clk);
    #1;
    chk("st_hold", 64'(st4), 64'h2);
    chk("mt_quiet", 64'(mt4), 64'h0);
    xfer(0, 1'b1, 32'hD00C, 32'hFFFF_FFFF, PRIV_M, 32'd0, 1'b0, "stcmp1_hi_max");
    chk("st_old_cmp", 64'(st4), 64'h2);
    @(posedge clk); #1;
    chk("st_new_cmp", 64'(st4), 64'h0);

    // 4: privilege
    xfer(0, 1'b1, 32'h0000, 32'd1, PRIV_S, 32'd0, 1'b1, "s_wr_msip0");
    chk("ms_after_s_wr", 64'(ms4), 64'h0);
    xfer(0, 1'b1, 32'hC000, 32'd1, PRIV_S, 32'd0, 1'b0, "s_wr_ssip0");
    chk("ss_after_s_wr", 64'(ss4), 64'h1);
    xfer(0, 1'b0, 32'hC000, 32'd0, 2'b00,  32'd0, 1'b1, "u_rd_ssip0");
    xfer(0, 1'b0, 32'hD00C, 32'd0, PRIV_S, 32'hFFFF_FFFF, 1'b0, "s_rd_stcmp1_hi");
    xfer(0, 1'b1, 32'h4000, 32'd5, PRIV_S, 32'd0, 1'b1, "s_wr_mtcmp0");
    xfer(0, 1'b0, 32'h4000, 32'd0, PRIV_M, 32'hFFFF_FFFF, 1'b0, "mtcmp0_unchanged");

    // 5: address errors
    xfer(0, 1'b0, 32'h4002, 32'd0, PRIV_M, 32'd0, 1'b1, "misaligned");
    xfer(0, 1'b1, 32'h8000, 32'd1, PRIV_M, 32'd0, 1'b1, "hole");
    xfer(0, 1'b0, 32'h0010, 32'd0, PRIV_M, 32'd0, 1'b1, "msip4_oob");
    xfer(1, 1'b1, 32'h000C, 32'd1, PRIV_M, 32'd0, 1'b1, "c3_msip3_wr");
    chk("c3_ms_after_oob", 64'(ms3), 64'h0);
    xfer(1, 1'b1, 32'h0008, 32'd1, PRIV_M, 32'd0, 1'b0, "c3_msip2_wr");
    chk("c3_ms_core2", 64'(ms3), 64'h4);
    xfer(1, 1'b0, 32'h000C, 32'd0, PRIV_M, 32'd0, 1'b1, "c3_msip3_rd");

    // 6: gated clock-enable, reset during SETUP
    en_mode = 1'b1;
    en_edge();
    tgt = 0; pwrite = 1'b1; paddr = 32'hC004; pwdata = 32'd1; pprot = PRIV_M;
    psel = 1'b1; penable = 1'b0;
    en_edge();
    penable = 1'b1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("midrst_pready", 64'(apb4.pready_clint), 64'd0);
    chk("midrst_perr",   64'(apb4.perr_clint),   64'd0);
    chk("midrst_prdata", 64'(apb4.prdata_clint), 64'd0);
    chk("midrst_ints",   64'({ms4, ss4, mt4, st4}), 64'd0);
    repeat (2) en_edge();
    chk("midrst_no_write", 64'(ss4), 64'h0);
    xfer(0, 1'b0, 32'hC004, 32'd0, PRIV_M, 32'd0, 1'b0, "gated_ssip1_rd");
    xfer(0, 1'b0, 32'hD008, 32'd0, PRIV_M, 32'hFFFF_FFFF, 1'b0, "gated_stcmp1_lo");
    xfer(0, 1'b1, 32'hC004, 32'd1, PRIV_M, 32'd0, 1'b0, "gated_ssip1_wr");
    chk("gated_ss_int", 64'(ss4), 64'h2);
    en_mode = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("c3_timer_ss_quiet", 64'({mt3, st3, ss3}), 64'd0);
    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
